// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's request/acknowledge port into the RAM arbiter
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two requesters onto one synchronous RAM, round-robin or A-first
module ram_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ram_arbiter_if.slave          a,
  ram_arbiter_if.slave          b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_data_output,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state;
  logic last_b, win_b, win_we;
  logic a_elig, b_elig, pick_b;
  // a port still showing its ack has just been served and must not be regranted yet
  always_comb begin
    a_elig = a.req && !a.ack;
    b_elig = b.req && !b.ack;
    pick_b = b_elig && (!a_elig || (FIXED_PRIORITY == 0 && !last_b));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_data <= '0;
      a.ack <= 1'b0;
      b.ack <= 1'b0;
      a.rdata <= '0;
      b.rdata <= '0;
      busy <= 1'b0;
      last_b <= 1'b1;
      win_b <= 1'b0;
      win_we <= 1'b0;
    end else begin
      a.ack <= 1'b0;
      b.ack <= 1'b0;
      case (state)
        IDLE: if (a_elig || b_elig) begin
          win_b <= pick_b;
          last_b <= pick_b;
          win_we <= pick_b ? b.we : a.we;
          mem_address <= pick_b ? b.addr : a.addr;
          mem_data <= pick_b ? b.wdata : a.wdata;
          mem_write <= pick_b ? b.we : a.we;
          mem_read <= pick_b ? !b.we : !a.we;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          mem_read <= 1'b0;
          mem_write <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (!win_we && !win_b) a.rdata <= mem_data_output;
          if (!win_we && win_b) b.rdata <= mem_data_output;
          a.ack <= !win_b;
          b.ack <= win_b;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: round-robin and fixed-priority arbiters driven side by side against a transaction model
module tb_ram_arbiter;
  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] data;
  } txn_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = !clk;
  logic rq [2][2];
  txn_t cur [2][2];
  txn_t q [2][2][$];
  logic gap;
  logic        o_ack [2][2];
  logic [31:0] o_rdat [2][2];
  logic        o_rd [2];
  logic        o_wr [2];
  logic [8:0]  o_addr [2];
  logic [31:0] o_data [2];
  logic        o_busy [2];
  logic [31:0] o_dout [2];
  int          cnt [2];
  logic        e_lastb [2];
  logic        win [2];
  logic        win_we [2];
  logic        e_ack [2][2];
  logic [31:0] e_rdat [2][2];
  logic        e_rd [2];
  logic        e_wr [2];
  logic [8:0]  e_addr [2];
  logic [31:0] e_data [2];
  logic [31:0] rval [2];
  logic [31:0] mm [2][512];
  int n_chk = 0;
  int n_err = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_arbiter_if ia ();
    ram_arbiter_if ib ();
    logic [31:0] ram [512] = '{default: '0};
    logic [31:0] dout = '0;
    assign ia.req = rq[g][0];
    assign ia.we = cur[g][0].we;
    assign ia.addr = cur[g][0].addr;
    assign ia.wdata = cur[g][0].data;
    assign ib.req = rq[g][1];
    assign ib.we = cur[g][1].we;
    assign ib.addr = cur[g][1].addr;
    assign ib.wdata = cur[g][1].data;
    assign o_ack[g][0] = ia.ack;
    assign o_ack[g][1] = ib.ack;
    assign o_rdat[g][0] = ia.rdata;
    assign o_rdat[g][1] = ib.rdata;
    assign o_dout[g] = dout;
    ram_arbiter #(.FIXED_PRIORITY(g)) dut (
      .clock(clk),
      .reset_n(reset_n),
      .a(ia),
      .b(ib),
      .mem_read(o_rd[g]),
      .mem_write(o_wr[g]),
      .mem_address(o_addr[g]),
      .mem_data(o_data[g]),
      .mem_data_output(o_dout[g]),
      .busy(o_busy[g])
    );
    always @(posedge clk) begin
      if (o_wr[g] === 1'b1) ram[o_addr[g]] <= o_data[g];
      if (o_rd[g] === 1'b1) dout <= ram[o_addr[g]];
    end
  end
  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask
  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      e_lastb[d] = 1'b1;
      win[d] = 1'b0;
      win_we[d] = 1'b0;
      e_rd[d] = 1'b0;
      e_wr[d] = 1'b0;
      e_addr[d] = '0;
      e_data[d] = '0;
      for (int p = 0; p < 2; p++) begin
        e_ack[d][p] = 1'b0;
        e_rdat[d][p] = '0;
      end
    end
  endtask
  // one clock edge of the transaction model: grant, RAM action, then result delivery
  task automatic model_edge();
    logic ea, eb, wb, na, nb;
    txn_t t;
    for (int d = 0; d < 2; d++) begin
      na = 1'b0;
      nb = 1'b0;
      if (cnt[d] == 0) begin
        ea = rq[d][0] && !e_ack[d][0];
        eb = rq[d][1] && !e_ack[d][1];
        if (ea || eb) begin
          wb = eb && (!ea || (d == 0 && !e_lastb[d]));
          t = cur[d][wb ? 1 : 0];
          e_lastb[d] = wb;
          win[d] = wb;
          win_we[d] = t.we;
          e_addr[d] = t.addr;
          e_data[d] = t.data;
          e_wr[d] = t.we;
          e_rd[d] = !t.we;
          cnt[d] = 2;
        end
      end else if (cnt[d] == 2) begin
        if (win_we[d]) mm[d][e_addr[d]] = e_data[d];
        rval[d] = mm[d][e_addr[d]];
        e_rd[d] = 1'b0;
        e_wr[d] = 1'b0;
        cnt[d] = 1;
      end else begin
        if (!win_we[d]) e_rdat[d][win[d] ? 1 : 0] = rval[d];
        na = !win[d];
        nb = win[d];
        cnt[d] = 0;
      end
      e_ack[d][0] = na;
      e_ack[d][1] = nb;
    end
  endtask
  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      chk("a_ack", d, 32'(o_ack[d][0]), 32'(e_ack[d][0]));
      chk("b_ack", d, 32'(o_ack[d][1]), 32'(e_ack[d][1]));
      chk("a_rdata", d, o_rdat[d][0], e_rdat[d][0]);
      chk("b_rdata", d, o_rdat[d][1], e_rdat[d][1]);
      chk("mem_read", d, 32'(o_rd[d]), 32'(e_rd[d]));
      chk("mem_write", d, 32'(o_wr[d]), 32'(e_wr[d]));
      chk("mem_address", d, 32'(o_addr[d]), 32'(e_addr[d]));
      chk("mem_data", d, o_data[d], e_data[d]);
      chk("busy", d, 32'(o_busy[d]), 32'(cnt[d] != 0));
      chk("rd_wr_excl", d, 32'(o_rd[d] && o_wr[d]), 32'd0);
    end
  endtask
  // requesters: retire on ack, then present the next queued access (optionally after one idle cycle)
  task automatic drive();
    logic acked;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        acked = e_ack[d][p];
        if (acked) begin
          q[d][p].delete(0);
          rq[d][p] = 1'b0;
        end
        if (!rq[d][p] && q[d][p].size() != 0 && !(acked && gap)) begin
          cur[d][p] = q[d][p][0];
          rq[d][p] = 1'b1;
        end
      end
  endtask
  task automatic cycle();
    drive();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    compare();
  endtask
  function automatic bit pending();
    for (int d = 0; d < 2; d++) begin
      if (cnt[d] != 0) return 1'b1;
      for (int p = 0; p < 2; p++)
        if (q[d][p].size() != 0 || rq[d][p] || e_ack[d][p]) return 1'b1;
    end
    return 1'b0;
  endfunction
  task automatic run(int lim);
    int c = 0;
    while (pending() && c < lim) begin
      cycle();
      c++;
    end
    chk("drain", 0, 32'(pending()), 32'd0);
  endtask
  task automatic push(int p, logic we, logic [8:0] addr, logic [31:0] data);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.data = data;
    q[0][p].push_back(t);
    q[1][p].push_back(t);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 512; i++) mm[d][i] = '0;
      rval[d] = '0;
      for (int p = 0; p < 2; p++) begin
        rq[d][p] = 1'b0;
        cur[d][p] = '0;
      end
    end
    gap = 1'b1;
    mreset();
    @(negedge clk);
    compare();
    reset_n = 1'b1;
    push(0, 1'b0, 9'd5, 32'h0);
    run(50);
    push(0, 1'b1, 9'h1ff, 32'hdeadbeef);
    push(0, 1'b0, 9'h1ff, 32'h0);
    run(50);
    gap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 9'd1, 32'h0);
      push(1, 1'b0, 9'd2, 32'h0);
    end
    run(100);
    gap = 1'b1;
    push(1, 1'b1, 9'd7, 32'h12345678);
    push(1, 1'b0, 9'd7, 32'h0);
    for (int c = 0; c < 20 && cnt[0] != 2; c++) cycle();
    reset_n = 1'b0;
    mreset();
    #1;
    compare();
    @(posedge clk);
    @(negedge clk);
    compare();
    reset_n = 1'b1;
    run(100);
    push(0, 1'b0, 9'd3, 32'h0);
    cycle();
    push(1, 1'b0, 9'd7, 32'h0);
    run(100);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0)
        push(int'($urandom_range(1)), 1'($urandom_range(1)),
             ($urandom_range(7) == 0) ? 9'h1ff : 9'($urandom_range(15)), $urandom);
      gap = 1'($urandom_range(1));
      cycle();
    end
    run(3000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
